regfile_2r1w: RTL and testbench

- Parametrised successor to the 4x8 datapath register file.
- Provides NUM_REGS registers of DATA_W bits, with:
  - one synchronous write port, sourced from the data bus or the ALU result;
  - two registered read ports: destination operand A, and source operand B or an immediate from the bus;
  - a flag register for zero, carry and similar flags.
- Sits between the instruction decoder/data bus and the ALU, and feeds stored values back onto the bus.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_if.sv | 42 ++++
 rtl/regfile_read_port.sv | 45 ++++
 rtl/regfile_2r1w.sv | 104 ++++++++++
 tb/tb_regfile_2r1w.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the parametrised 2-read/1-write register file:
// write-source encodings, flag bit positions and default geometry.
package regfile_pkg;

  localparam int DEFAULT_DATA_W   = 8;
  localparam int DEFAULT_NUM_REGS = 4;
  localparam int DEFAULT_FLAG_W   = 2;

  localparam logic WR_SRC_BUS = 1'b0;
  localparam logic WR_SRC_ALU = 1'b1;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

endpackage

// File: rtl/regfile_if.sv
// Decoder/ALU-facing bus of the register file; the decoder side is the master,
// the register file is the slave.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int FLAG_W   = DEFAULT_FLAG_W
);
  localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic              en;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr_dst;
  logic [ADDR_W-1:0] rd_addr_src;
  logic              direct_immediate;
  logic [DATA_W-1:0] data_bus_in;
  logic [DATA_W-1:0] alu_result;
  logic              flags_we;
  logic [FLAG_W-1:0] flags_in;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              out_valid;
  logic [DATA_W-1:0] data_bus_out;
  logic [FLAG_W-1:0] flags_out;

  modport master (
    output en, wr_en, wr_sel, wr_addr, rd_req, rd_addr_dst, rd_addr_src,
           direct_immediate, data_bus_in, alu_result, flags_we, flags_in,
    input  op_a, op_b, out_valid, data_bus_out, flags_out
  );

  modport slave (
    input  en, wr_en, wr_sel, wr_addr, rd_req, rd_addr_dst, rd_addr_src,
           direct_immediate, data_bus_in, alu_result, flags_we, flags_in,
    output op_a, op_b, out_valid, data_bus_out, flags_out
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: range check, write-first bypass, and an optional
// immediate select (tie use_reg high when the port has no immediate).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  localparam int ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              use_reg,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W + 1)'(NUM_REGS);

  logic              in_range_s;
  logic              hit_s;
  logic [DATA_W-1:0] reg_val_s;

  // An out-of-range address reads zero even if a write targets it on this edge.
  always_comb begin
    in_range_s = ({1'b0, rd_addr} < NUM_REGS_C);
    hit_s      = wr_fire && (wr_addr == rd_addr);
    reg_val_s  = {DATA_W{1'b0}};
    if (!in_range_s) begin
      reg_val_s = {DATA_W{1'b0}};
    end else if (hit_s) begin
      reg_val_s = wr_data;
    end else begin
      reg_val_s = regs[rd_addr];
    end
    if (use_reg) begin
      rd_data = reg_val_s;
    end else begin
      rd_data = imm;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised datapath register file: one synchronous write port, two registered
// read ports with write-first bypass, and an independent flag register.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int                DATA_W    = DEFAULT_DATA_W,
  parameter int                NUM_REGS  = DEFAULT_NUM_REGS,
  parameter int                FLAG_W    = DEFAULT_FLAG_W,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}},
  localparam int               ADDR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input logic      clk,
  input logic      reset,
  regfile_if.slave bus
);

  localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic [DATA_W-1:0] op_a_r;
  logic [DATA_W-1:0] op_b_r;
  logic              out_valid_r;
  logic [FLAG_W-1:0] flags_r;

  logic [DATA_W-1:0] wr_data_s;
  logic              wr_fire_s;
  logic              wr_ok_s;
  logic [DATA_W-1:0] rd_a_s;
  logic [DATA_W-1:0] rd_b_s;

  // Write data source and qualification.
  always_comb begin
    wr_fire_s = bus.en && bus.wr_en;
    wr_ok_s   = wr_fire_s && ({1'b0, bus.wr_addr} < NUM_REGS_C);
    case (bus.wr_sel)
      WR_SRC_BUS: wr_data_s = bus.data_bus_in;
      WR_SRC_ALU: wr_data_s = bus.alu_result;
      default:    wr_data_s = bus.data_bus_in;
    endcase
  end

  regfile_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_port_a (
    .regs    (regs_r),
    .rd_addr (bus.rd_addr_dst),
    .wr_fire (wr_fire_s),
    .wr_addr (bus.wr_addr),
    .wr_data (wr_data_s),
    .use_reg (1'b1),
    .imm     ({DATA_W{1'b0}}),
    .rd_data (rd_a_s)
  );

  regfile_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_port_b (
    .regs    (regs_r),
    .rd_addr (bus.rd_addr_src),
    .wr_fire (wr_fire_s),
    .wr_addr (bus.wr_addr),
    .wr_data (wr_data_s),
    .use_reg (bus.direct_immediate),
    .imm     (bus.data_bus_in),
    .rd_data (rd_b_s)
  );

  // Register storage; out-of-range writes never reach the array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= RESET_VAL;
      end
    end else if (wr_ok_s) begin
      regs_r[bus.wr_addr] <= wr_data_s;
    end
  end

  // Operand and flag registers; out_valid pulses for one cycle per read request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a_r      <= {DATA_W{1'b0}};
      op_b_r      <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      flags_r     <= {FLAG_W{1'b0}};
    end else if (bus.en) begin
      if (bus.rd_req) begin
        op_a_r      <= rd_a_s;
        op_b_r      <= rd_b_s;
        out_valid_r <= 1'b1;
      end else begin
        out_valid_r <= 1'b0;
      end
      if (bus.flags_we) begin
        flags_r <= bus.flags_in;
      end
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.op_a         = op_a_r;
  assign bus.op_b         = op_b_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.data_bus_out = op_a_r;
  assign bus.flags_out    = flags_r;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: directed vector table, reset and NUM_REGS=3 sequences,
// then randomized traffic against a behavioural model of the 4-register file.
module tb_regfile_2r1w;
  import regfile_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  regfile_if #(.DATA_W(8), .NUM_REGS(4), .FLAG_W(2)) b4 ();
  regfile_if #(.DATA_W(8), .NUM_REGS(3), .FLAG_W(2)) b3 ();

  regfile_2r1w #(.DATA_W(8), .NUM_REGS(4), .FLAG_W(2), .RESET_VAL(8'h00)) u4 (
    .clk(clk), .reset(reset), .bus(b4)
  );
  regfile_2r1w #(.DATA_W(8), .NUM_REGS(3), .FLAG_W(2), .RESET_VAL(8'h00)) u3 (
    .clk(clk), .reset(reset), .bus(b3)
  );

  typedef struct {
    logic       en, wr_en, wr_sel;
    logic [1:0] wr_addr;
    logic       rd_req;
    logic [1:0] dst, src;
    logic       di;
    logic [7:0] bus, alu;
    logic       fwe;
    logic [1:0] fin;
    logic [7:0] ea, eb;
    logic       ev;
    logic [1:0] ef;
  } vec_t;

  vec_t vecs [14];

  // Behavioural model of the 4-register instance: registers as a plain array,
  // reads see a same-edge write to the same index.
  logic [7:0] m_regs [4];
  logic [7:0] m_a, m_b;
  logic       m_v;
  logic [1:0] m_f;

  function automatic logic [7:0] m_read(input logic [1:0] x);
    if (b4.wr_en && b4.wr_addr == x)
      return b4.wr_sel ? b4.alu_result : b4.data_bus_in;
    return m_regs[x];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_regs[i] <= 8'h00;
      m_a <= 8'h00; m_b <= 8'h00; m_v <= 1'b0; m_f <= 2'b00;
    end else if (b4.en) begin
      m_v <= b4.rd_req;
      if (b4.rd_req) begin
        m_a <= m_read(b4.rd_addr_dst);
        m_b <= b4.direct_immediate ? m_read(b4.rd_addr_src) : b4.data_bus_in;
      end
      if (b4.wr_en) m_regs[b4.wr_addr] <= b4.wr_sel ? b4.alu_result : b4.data_bus_in;
      if (b4.flags_we) m_f <= b4.flags_in;
    end else begin
      m_v <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                      input logic ev, input logic [1:0] ef);
    chk({tag, "/op_a"}, b4.op_a, ea);
    chk({tag, "/op_b"}, b4.op_b, eb);
    chk({tag, "/out_valid"}, {7'd0, b4.out_valid}, {7'd0, ev});
    chk({tag, "/data_bus_out"}, b4.data_bus_out, ea);
    chk({tag, "/flags_out"}, {6'd0, b4.flags_out}, {6'd0, ef});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle4();
    b4.en = 1'b0; b4.wr_en = 1'b0; b4.wr_sel = 1'b0; b4.wr_addr = 2'd0;
    b4.rd_req = 1'b0; b4.rd_addr_dst = 2'd0; b4.rd_addr_src = 2'd0;
    b4.direct_immediate = 1'b1; b4.data_bus_in = 8'h00; b4.alu_result = 8'h00;
    b4.flags_we = 1'b0; b4.flags_in = 2'b00;
  endtask

  task automatic idle3();
    b3.en = 1'b0; b3.wr_en = 1'b0; b3.wr_sel = 1'b0; b3.wr_addr = 2'd0;
    b3.rd_req = 1'b0; b3.rd_addr_dst = 2'd0; b3.rd_addr_src = 2'd0;
    b3.direct_immediate = 1'b1; b3.data_bus_in = 8'h00; b3.alu_result = 8'h00;
    b3.flags_we = 1'b0; b3.flags_in = 2'b00;
  endtask

  task automatic apply_vec(input vec_t v);
    b4.en = v.en; b4.wr_en = v.wr_en; b4.wr_sel = v.wr_sel; b4.wr_addr = v.wr_addr;
    b4.rd_req = v.rd_req; b4.rd_addr_dst = v.dst; b4.rd_addr_src = v.src;
    b4.direct_immediate = v.di; b4.data_bus_in = v.bus; b4.alu_result = v.alu;
    b4.flags_we = v.fwe; b4.flags_in = v.fin;
  endtask

  task automatic w3(input logic [1:0] addr, input logic [7:0] data);
    b3.en = 1'b1; b3.wr_en = 1'b1; b3.wr_sel = 1'b0; b3.wr_addr = addr;
    b3.data_bus_in = data; b3.rd_req = 1'b0;
    tick();
  endtask

  task automatic r3(input string tag, input logic [1:0] dst, input logic [1:0] src,
                    input logic [7:0] ea, input logic [7:0] eb);
    b3.en = 1'b1; b3.rd_req = 1'b1; b3.rd_addr_dst = dst; b3.rd_addr_src = src;
    b3.direct_immediate = 1'b1;
    tick();
    chk({tag, "/op_a"}, b3.op_a, ea);
    chk({tag, "/op_b"}, b3.op_b, eb);
    chk({tag, "/out_valid"}, {7'd0, b3.out_valid}, 8'h01);
  endtask

  initial begin
    //            en    wr    sel   wadr  rd    dst   src   di    bus    alu    fwe   fin                 ea     eb     ev    ef
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 2'd0, 1'b1, 8'h3C, 8'h00, 1'b0, 2'b00,            8'h00, 8'h00, 1'b0, 2'b00};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 2'd2, 1'b1, 8'h00, 8'h00, 1'b0, 2'b00,            8'h3C, 8'h3C, 1'b1, 2'b00};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 8'h00, 8'h00, 1'b0, 2'b00,            8'h3C, 8'h3C, 1'b0, 2'b00};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 8'h11, 8'h00, 1'b0, 2'b00,            8'h3C, 8'h3C, 1'b0, 2'b00};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd1, 1'b0, 8'hA5, 8'h00, 1'b0, 2'b00,            8'h11, 8'hA5, 1'b1, 2'b00};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 2'd0, 2'd0, 1'b1, 8'h99, 8'h00, 1'b0, 2'b00,            8'h11, 8'hA5, 1'b0, 2'b00};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 2'd3, 2'd3, 1'b1, 8'h99, 8'h77, 1'b0, 2'b00,            8'h77, 8'h77, 1'b1, 2'b00};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 2'd0, 1'b1, 8'h00, 8'h00, 1'b0, 2'b00,            8'h77, 8'h11, 1'b1, 2'b00};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 2'd2, 1'b1, 8'hEE, 8'h00, 1'b1, 2'b11,            8'h77, 8'h11, 1'b0, 2'b00};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd2, 1'b1, 8'h00, 8'h00, 1'b1, 2'(1 << FLAG_C), 8'h11, 8'h3C, 1'b1, 2'b10};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 2'd1, 2'd0, 1'b1, 8'h42, 8'h00, 1'b0, 2'b00,            8'h42, 8'h11, 1'b1, 2'b10};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 8'h00, 8'h00, 1'b0, 2'b01,            8'h42, 8'h11, 1'b0, 2'b10};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 2'd0, 1'b1, 8'h00, 8'h5B, 1'b0, 2'b00,            8'h5B, 8'h5B, 1'b1, 2'b10};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 2'd3, 1'b0, 8'hC3, 8'h00, 1'b1, 2'(1 << FLAG_Z), 8'h3C, 8'hC3, 1'b1, 2'b01};

    idle4();
    idle3();
    tick();
    chk4("reset_state", 8'h00, 8'h00, 1'b0, 2'b00);
    chk("reset_state/u3_op_a", b3.op_a, 8'h00);

    // Reset raised between driving a write of 0x5A to r1 and its clock edge.
    reset = 1'b0;
    b4.en = 1'b1; b4.wr_en = 1'b1; b4.wr_addr = 2'd1; b4.data_bus_in = 8'h5A;
    b4.rd_req = 1'b1; b4.rd_addr_dst = 2'd1; b4.rd_addr_src = 2'd1;
    #2;
    reset = 1'b1;
    tick();
    chk4("reset_mid_write", 8'h00, 8'h00, 1'b0, 2'b00);
    reset = 1'b0;
    b4.wr_en = 1'b0; b4.data_bus_in = 8'h00;
    tick();
    chk4("after_reset_read_r1", 8'h00, 8'h00, 1'b1, 2'b00);

    for (int i = 0; i < 14; i++) begin
      apply_vec(vecs[i]);
      tick();
      chk4($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ev, vecs[i].ef);
    end

    // Asynchronous reset clears outputs without waiting for a clock edge.
    idle4();
    reset = 1'b1;
    #1;
    chk4("async_reset", 8'h00, 8'h00, 1'b0, 2'b00);
    tick();
    reset = 1'b0;
    b4.en = 1'b1; b4.rd_req = 1'b1; b4.rd_addr_dst = 2'd2; b4.rd_addr_src = 2'd3;
    tick();
    chk4("regs_cleared", 8'h00, 8'h00, 1'b1, 2'b00);
    idle4();

    // Three-register instance: index 3 is unmapped for both write and read.
    w3(2'd0, 8'h10);
    w3(2'd1, 8'h20);
    w3(2'd2, 8'h30);
    w3(2'd3, 8'hFF);
    b3.wr_en = 1'b0;
    r3("n3_r0_r1", 2'd0, 2'd1, 8'h10, 8'h20);
    r3("n3_r2_r3", 2'd2, 2'd3, 8'h30, 8'h00);
    b3.wr_en = 1'b1; b3.wr_addr = 2'd3; b3.data_bus_in = 8'hEE;
    r3("n3_bypass_r3", 2'd3, 2'd3, 8'h00, 8'h00);
    b3.wr_en = 1'b0; b3.data_bus_in = 8'h00;
    r3("n3_r0_r2_kept", 2'd0, 2'd2, 8'h10, 8'h30);
    idle3();

    for (int c = 0; c < 400; c++) begin
      b4.en               = ($urandom_range(0, 7) != 0);
      b4.wr_en            = 1'($urandom_range(0, 1));
      b4.wr_sel           = 1'($urandom_range(0, 1));
      b4.wr_addr          = 2'($urandom_range(0, 3));
      b4.rd_req           = ($urandom_range(0, 3) != 0);
      b4.rd_addr_dst      = 2'($urandom_range(0, 3));
      b4.rd_addr_src      = 2'($urandom_range(0, 3));
      b4.direct_immediate = 1'($urandom_range(0, 1));
      b4.data_bus_in      = 8'($urandom);
      b4.alu_result       = 8'($urandom);
      b4.flags_we         = ($urandom_range(0, 3) == 0);
      b4.flags_in         = 2'($urandom_range(0, 3));
      tick();
      tests++;
      if (b4.op_a !== m_a || b4.op_b !== m_b || b4.out_valid !== m_v ||
          b4.data_bus_out !== m_a || b4.flags_out !== m_f) begin
        fails++;
        $display("FAIL rand%0d: got a=%02h b=%02h v=%0b dbo=%02h f=%0b, expected a=%02h b=%02h v=%0b f=%0b",
                 c, b4.op_a, b4.op_b, b4.out_valid, b4.data_bus_out, b4.flags_out,
                 m_a, m_b, m_v, m_f);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
